// File: rtl/data_mem_responder.sv
// data_mem_responder: single-ported word memory behind a valid/ready
// request/response handshake with a programmable number of wait states.
// Optional feature: define DMEM_MISALIGN_ERR_EN to add the resp_err port and
// reject requests whose byte address is not word aligned.
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata
`ifdef DMEM_MISALIGN_ERR_EN
    ,
    output logic        resp_err
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        enter_resp;
    logic        cur_write;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [AW-1:0] idx;
    logic        cur_mis;
    logic        unused_addr;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = (state == IDLE) && req_valid;

    // With zero wait states the commit happens on the accept edge itself, so
    // the transaction fields come straight from the request port in IDLE.
    assign cur_write = (state == IDLE) ? req_write : wr_q;
    assign cur_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata : wdata_q;

    assign enter_resp = (WAIT_CYCLES == 0) ? accept
                                           : ((state == WAIT) && (cnt == 4'd0));

    // Upper address bits wrap the array; byte offset only matters for the error check.
    assign idx         = cur_addr[AW+1:2];
    assign unused_addr = ^{cur_addr[31:AW+2], cur_addr[1:0]};

`ifdef DMEM_MISALIGN_ERR_EN
    assign cur_mis = (cur_addr[1:0] != 2'b00);
`else
    assign cur_mis = 1'b0;
`endif

    // Control FSM: IDLE -> (WAIT) -> RESP -> IDLE, with wait-state counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (WAIT_CYCLES == 0) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture the request fields on the accept edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Store commit on the edge entering RESP; a reset before then drops it.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && cur_write && !cur_mis) begin
            mem[idx] <= cur_wdata;
        end
    end

    // Response data captured on entry to RESP and held until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_rdata <= 32'd0;
        end else if (enter_resp) begin
            resp_rdata <= (cur_write || cur_mis) ? 32'd0 : mem[idx];
        end
    end

`ifdef DMEM_MISALIGN_ERR_EN
    // Error flag follows the same capture timing as the read data.
    always_ff @(posedge clk) begin
        if (rst)             resp_err <= 1'b0;
        else if (enter_resp) resp_err <= cur_mis;
    end
`endif

endmodule
